// File: rtl/systolic_ctrl.sv
// Sequencer for a 2x2 weight-stationary systolic array: loads a weight tile,
// streams skewed input vectors and deskews the two south columns into result beats.
module systolic_ctrl #(
    parameter int DATA_W  = 16,
    parameter int MAX_VEC = 256,
    parameter int CNT_W   = $clog2(MAX_VEC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_num_vec,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data_1,
    input  logic [DATA_W-1:0] w_data_2,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data_1,
    input  logic [DATA_W-1:0] x_data_2,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data_1,
    output logic [DATA_W-1:0] res_data_2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sys_weight_in_11,
    output logic [DATA_W-1:0] sys_weight_in_12,
    output logic              sys_accept_w_in,
    output logic              sys_switch_in,
    output logic [DATA_W-1:0] sys_data_in_11,
    output logic [DATA_W-1:0] sys_data_in_21,
    output logic              sys_start,
    input  logic [DATA_W-1:0] sys_data_out_21,
    input  logic [DATA_W-1:0] sys_data_out_22,
    input  logic              sys_valid_out_21,
    input  logic              sys_valid_out_22
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SWITCH,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  num_vec;
    logic [CNT_W-1:0]  x_cnt;
    logic [CNT_W-1:0]  res_cnt;
    logic [1:0]        w_cnt;
    logic [DATA_W-1:0] x2_pipe;
    logic [DATA_W-1:0] col1_reg;
    logic              w_fire;
    logic              x_fire;
    logic              res_fire;

    assign w_fire = w_valid && w_ready;
    assign x_fire = x_valid && x_ready;

    // Column 2 lags column 1 by one cycle, so the held column-1 value belongs to
    // the same vector; results are only forwarded while a command expects them.
    assign res_fire   = sys_valid_out_22 && ((state == STREAM) || (state == DRAIN))
                        && (res_cnt != num_vec);
    assign res_valid  = res_fire;
    assign res_data_1 = res_fire ? col1_reg : '0;
    assign res_data_2 = res_fire ? sys_data_out_22 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            num_vec          <= '0;
            x_cnt            <= '0;
            res_cnt          <= '0;
            w_cnt            <= '0;
            x2_pipe          <= '0;
            col1_reg         <= '0;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            w_ready          <= 1'b0;
            x_ready          <= 1'b0;
            sys_weight_in_11 <= '0;
            sys_weight_in_12 <= '0;
            sys_accept_w_in  <= 1'b0;
            sys_switch_in    <= 1'b0;
            sys_data_in_11   <= '0;
            sys_data_in_21   <= '0;
            sys_start        <= 1'b0;
        end else begin
            sys_accept_w_in  <= w_fire;
            sys_weight_in_11 <= w_fire ? w_data_1 : '0;
            sys_weight_in_12 <= w_fire ? w_data_2 : '0;

            // Row 2 receives its element one cycle after row 1 to match the array skew.
            sys_start      <= x_fire;
            sys_data_in_11 <= x_fire ? x_data_1 : '0;
            x2_pipe        <= x_fire ? x_data_2 : '0;
            sys_data_in_21 <= x2_pipe;

            if (sys_valid_out_21) begin
                col1_reg <= sys_data_out_21;
            end
            if (res_fire) begin
                res_cnt <= res_cnt + CNT_W'(1);
            end

            sys_switch_in <= 1'b0;
            done          <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        num_vec   <= cmd_num_vec;
                        x_cnt     <= '0;
                        res_cnt   <= '0;
                        w_cnt     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        w_ready   <= 1'b1;
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    // Stay one extra cycle after the second beat so its drive
                    // precedes the swap pulse.
                    if (w_fire) begin
                        w_cnt <= w_cnt + 2'd1;
                        if (w_cnt == 2'd1) begin
                            w_ready <= 1'b0;
                        end
                    end else if (w_cnt == 2'd2) begin
                        sys_switch_in <= 1'b1;
                        state         <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (num_vec == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x_ready <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (x_fire) begin
                        x_cnt <= x_cnt + CNT_W'(1);
                        if (x_cnt == num_vec - CNT_W'(1)) begin
                            x_ready <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (res_cnt == num_vec) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: a behavioural 2x2 array model answers the
// array ports, and expected results come from the matrix-vector rule per command.
module tb_systolic_ctrl;

    localparam int DATA_W  = 16;
    localparam int MAX_VEC = 256;
    localparam int CNT_W   = $clog2(MAX_VEC + 1);

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_num_vec;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data_1;
    logic [DATA_W-1:0] w_data_2;
    logic              x_valid;
    logic              x_ready;
    logic [DATA_W-1:0] x_data_1;
    logic [DATA_W-1:0] x_data_2;
    logic              res_valid;
    logic [DATA_W-1:0] res_data_1;
    logic [DATA_W-1:0] res_data_2;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] sys_weight_in_11;
    logic [DATA_W-1:0] sys_weight_in_12;
    logic              sys_accept_w_in;
    logic              sys_switch_in;
    logic [DATA_W-1:0] sys_data_in_11;
    logic [DATA_W-1:0] sys_data_in_21;
    logic              sys_start;
    logic [DATA_W-1:0] sys_data_out_21;
    logic [DATA_W-1:0] sys_data_out_22;
    logic              sys_valid_out_21;
    logic              sys_valid_out_22;

    systolic_ctrl #(.DATA_W(DATA_W), .MAX_VEC(MAX_VEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_vec(cmd_num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data_1(w_data_1), .w_data_2(w_data_2),
        .x_valid(x_valid), .x_ready(x_ready), .x_data_1(x_data_1), .x_data_2(x_data_2),
        .res_valid(res_valid), .res_data_1(res_data_1), .res_data_2(res_data_2),
        .busy(busy), .done(done),
        .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
        .sys_accept_w_in(sys_accept_w_in), .sys_switch_in(sys_switch_in),
        .sys_data_in_11(sys_data_in_11), .sys_data_in_21(sys_data_in_21),
        .sys_start(sys_start),
        .sys_data_out_21(sys_data_out_21), .sys_data_out_22(sys_data_out_22),
        .sys_valid_out_21(sys_valid_out_21), .sys_valid_out_22(sys_valid_out_22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] d;
    } ev_t;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] sb[$];
    logic [15:0] xs1[$];
    logic [15:0] xs2[$];
    ev_t         q1[$];
    ev_t         q2[$];
    int          cyc = 0;
    int          cur_n = 0;
    int          done_cnt = 0;
    int          acc_w_cnt = 0;
    int          sw_cnt = 0;
    int          sw_cyc = 0;
    int          start_cnt = 0;
    int          xr_cnt = 0;
    int          res_seen = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Q8.8 dot product of two element pairs, as the array's PEs compute it.
    function automatic logic [15:0] qdot(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        int sa, sb_, sc, sd, acc;
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        sc  = int'($signed(c));
        sd  = int'($signed(d));
        acc = (sa * sb_ + sc * sd) >>> 8;
        return acc[15:0];
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    task automatic randomFill(input int n);
        xs1.delete();
        xs2.delete();
        for (int i = 0; i < n; i++) begin
            xs1.push_back(rnd16());
            xs2.push_back(rnd16());
        end
    endtask

    // Array model on the post-edge side, scoreboard monitor on the falling edge.
    initial begin
        logic [15:0] sh11, sh12, sh21, sh22, a11, a12, a21, a22, pend_x1;
        logic        pend;
        logic [15:0] r1, r2;
        ev_t         ev;
        logic [31:0] e;
        sh11 = '0; sh12 = '0; sh21 = '0; sh22 = '0;
        a11 = '0; a12 = '0; a21 = '0; a22 = '0;
        pend = 1'b0; pend_x1 = '0;
        sys_valid_out_21 = 1'b0; sys_valid_out_22 = 1'b0;
        sys_data_out_21 = '0; sys_data_out_22 = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                sb.delete();
                acc_w_cnt = 0; sw_cnt = 0; start_cnt = 0; xr_cnt = 0; res_seen = 0;
            end
            if (sys_accept_w_in) begin
                sh21 = sh11; sh22 = sh12;
                sh11 = sys_weight_in_11; sh12 = sys_weight_in_12;
            end else begin
                checkOutput("w_ports_idle", {sys_weight_in_11, sys_weight_in_12}, 32'h0);
            end
            if (sys_switch_in) begin
                a11 = sh11; a12 = sh12; a21 = sh21; a22 = sh22;
            end
            if (pend) begin
                r1 = qdot(pend_x1, a11, sys_data_in_21, a21);
                r2 = qdot(pend_x1, a12, sys_data_in_21, a22);
                q1.push_back('{cyc + 1, r1});
                q2.push_back('{cyc + 2, r2});
            end else begin
                checkOutput("din21_idle", {16'h0, sys_data_in_21}, 32'h0);
            end
            if (!sys_start) checkOutput("din11_idle", {16'h0, sys_data_in_11}, 32'h0);
            pend    = sys_start;
            pend_x1 = sys_data_in_11;
            sys_valid_out_21 = 1'b0; sys_data_out_21 = '0;
            sys_valid_out_22 = 1'b0; sys_data_out_22 = '0;
            if (q1.size() > 0 && q1[0].t == cyc) begin
                ev = q1.pop_front();
                sys_valid_out_21 = 1'b1; sys_data_out_21 = ev.d;
            end
            if (q2.size() > 0 && q2[0].t == cyc) begin
                ev = q2.pop_front();
                sys_valid_out_22 = 1'b1; sys_data_out_22 = ev.d;
            end

            @(negedge clk);
            if (!rst) begin
                checkOutput("busy_vs_ready", {31'h0, busy}, {31'h0, !cmd_ready});
                if (sys_accept_w_in) acc_w_cnt++;
                if (sys_switch_in) begin sw_cnt++; sw_cyc = cyc; end
                if (sys_start) start_cnt++;
                if (x_ready) xr_cnt++;
                if (res_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("stray_res_valid", 32'h1, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("res_data_1", {16'h0, res_data_1}, {16'h0, e[31:16]});
                        checkOutput("res_data_2", {16'h0, res_data_2}, {16'h0, e[15:0]});
                        res_seen++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    checkOutput("res_count", res_seen, cur_n);
                    checkOutput("sb_empty", sb.size(), 0);
                    checkOutput("accept_w_cycles", acc_w_cnt, 2);
                    checkOutput("switch_pulses", sw_cnt, 1);
                    checkOutput("start_count", start_cnt, cur_n);
                    if (cur_n == 0) begin
                        checkOutput("x_ready_cycles", xr_cnt, 0);
                        checkOutput("done_after_switch", cyc, sw_cyc + 1);
                    end
                    acc_w_cnt = 0; sw_cnt = 0; start_cnt = 0; xr_cnt = 0; res_seen = 0;
                end
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
        checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
        checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
        checkOutput({tag, "_res"}, {15'h0, res_valid, res_data_1}, 32'h0);
        checkOutput({tag, "_res2"}, {16'h0, res_data_2}, 32'h0);
        checkOutput({tag, "_readies"}, {30'h0, w_ready, x_ready}, 32'h0);
        checkOutput({tag, "_w_ports"}, {sys_weight_in_11, sys_weight_in_12}, 32'h0);
        checkOutput({tag, "_ctl"}, {29'h0, sys_accept_w_in, sys_switch_in, sys_start}, 32'h0);
        checkOutput({tag, "_x_ports"}, {sys_data_in_11, sys_data_in_21}, 32'h0);
    endtask

    // Runs one command; abort_at >= 0 applies reset after that many x beats.
    task automatic applyStimulus(input int n, input logic [15:0] w11, input logic [15:0] w12,
                                 input logic [15:0] w21, input logic [15:0] w22,
                                 input int w_gap, input int x_mode, input int abort_at,
                                 input bit noisy_cmd);
        int  budget, k, d0;
        bit  v, acc;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_num_vec = CNT_W'(n);
        budget = 0;
        while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
        if (!cmd_ready) begin
            checkOutput("cmd_accept_timeout", 32'h0, 32'h1);
            cmd_valid = 1'b0;
            return;
        end
        cur_n = n;
        for (int i = 0; i < n; i++) begin
            sb.push_back({qdot(xs1[i], w11, xs2[i], w21), qdot(xs1[i], w12, xs2[i], w22)});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_num_vec = CNT_W'($urandom_range(1, 9));
        for (int b = 0; b < 2; b++) begin
            if (b == 1) begin
                for (int g = 0; g < w_gap; g++) begin
                    w_valid = 1'b0; w_data_1 = rnd16(); w_data_2 = rnd16();
                    @(negedge clk);
                end
            end
            w_valid  = 1'b1;
            w_data_1 = (b == 0) ? w21 : w11;
            w_data_2 = (b == 0) ? w22 : w12;
            budget = 0;
            while (!w_ready && budget < 50) begin @(negedge clk); budget++; end
            if (!w_ready) begin
                checkOutput("w_accept_timeout", 32'h0, 32'h1);
                w_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_data_1 = '0; w_data_2 = '0;
        if (n == 0) begin
            x_valid = 1'b1; x_data_1 = rnd16(); x_data_2 = rnd16();
            repeat (4) @(negedge clk);
            x_valid = 1'b0;
        end
        k = 0;
        budget = 0;
        while (k < n && budget < 4000) begin
            if (abort_at >= 0 && k == abort_at) break;
            if (noisy_cmd) cmd_valid = 1'b1;
            v = (x_mode == 0) ? 1'b1 : (x_mode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
            x_valid  = v;
            x_data_1 = v ? xs1[k] : rnd16();
            x_data_2 = v ? xs2[k] : rnd16();
            acc = v && x_ready;
            @(negedge clk);
            budget++;
            if (acc) k++;
        end
        x_valid = 1'b0; x_data_1 = '0; x_data_2 = '0;
        cmd_valid = 1'b0;
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            checkReset("midrst");
            rst = 1'b0;
            repeat (12) @(negedge clk);
            checkReset("postrst");
            return;
        end
        if (k < n) checkOutput("x_stream_timeout", k, n);
        budget = 0;
        while (done_cnt == d0 && budget < 2000) begin @(negedge clk); budget++; end
        if (done_cnt == d0) checkOutput("done_timeout", 32'h0, 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("done_pulses", done_cnt, d0 + 1);
        checkOutput("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_num_vec = '0;
        w_valid = 1'b0; w_data_1 = '0; w_data_2 = '0;
        x_valid = 1'b0; x_data_1 = '0; x_data_2 = '0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);
        checkReset("idle");

        $display("[TB] identity-ish weights, single vector");
        xs1 = '{16'h0100}; xs2 = '{16'h0100};
        applyStimulus(1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, -1, 1'b0);

        $display("[TB] four vectors with toggling x_valid");
        randomFill(4);
        applyStimulus(4, rnd16(), rnd16(), rnd16(), rnd16(), 0, 1, -1, 1'b0);

        $display("[TB] zero-vector command");
        randomFill(0);
        applyStimulus(0, rnd16(), rnd16(), rnd16(), rnd16(), 0, 0, -1, 1'b0);

        $display("[TB] weight gap of three cycles");
        randomFill(3);
        applyStimulus(3, rnd16(), rnd16(), rnd16(), rnd16(), 3, 2, -1, 1'b0);

        $display("[TB] full-length command with cmd_valid while busy");
        randomFill(MAX_VEC);
        applyStimulus(MAX_VEC, rnd16(), rnd16(), rnd16(), rnd16(), 1, 0, -1, 1'b1);

        $display("[TB] random commands");
        for (int r = 0; r < 5; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            randomFill(n);
            applyStimulus(n, rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(0, 3)), 2, -1, 1'b0);
        end

        $display("[TB] reset in the middle of streaming");
        randomFill(8);
        applyStimulus(8, rnd16(), rnd16(), rnd16(), rnd16(), 0, 0, 3, 1'b0);

        $display("[TB] recovery after reset");
        randomFill(2);
        applyStimulus(2, rnd16(), rnd16(), rnd16(), rnd16(), 0, 2, -1, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
